redun_normalizer: RTL and testbench



---
 rtl/redun_normalizer.sv | 127 ++++++++++++
 tb/tb_redun_normalizer.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/redun_normalizer.sv
// Carry-propagates one packet of redundant column words into a serial, LSW-first stream of canonical words.
// Optional extra final-carry beat: define REDUN_NORM_CARRY_BEAT_EN.
module redun_normalizer #(
    parameter int NUM_WORDS  = 66,
    parameter int IN_BIT_LEN = 17,
    parameter int WORD_LEN   = 16,
    parameter int CARRY_LEN  = IN_BIT_LEN - WORD_LEN + 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [IN_BIT_LEN-1:0] in_words [NUM_WORDS],
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WORD_LEN-1:0]   out_word,
    output logic                  out_last,
    output logic [CARRY_LEN-1:0]  out_carry
);
    localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam int SUM_W = IN_BIT_LEN + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

    typedef enum logic [1:0] {IDLE, RUN, CARRY} state_t;

    state_t                state_p0;
    logic [IN_BIT_LEN-1:0] word_buf_p0 [NUM_WORDS];
    logic [IDX_W-1:0]      idx_p0;
    logic [CARRY_LEN-1:0]  carry_p0;

    logic [SUM_W-1:0]      sum;
    logic [CARRY_LEN-1:0]  carry_nxt;
    logic                  is_last;

    function automatic logic [SUM_W-1:0] add_carry(input logic [IN_BIT_LEN-1:0] w,
                                                   input logic [CARRY_LEN-1:0]  c);
        return {1'b0, w} + {{(SUM_W-CARRY_LEN){1'b0}}, c};
    endfunction

    function automatic logic [CARRY_LEN-1:0] carry_of(input logic [SUM_W-1:0] s);
        return s[SUM_W-1:WORD_LEN];
    endfunction

    // Stage p0: packet buffer (data only, never reset)
    always_ff @(posedge clk) begin
        if (state_p0 == IDLE && in_valid) begin
            word_buf_p0 <= in_words;
        end
    end

    assign sum       = add_carry(word_buf_p0[idx_p0], carry_p0);
    assign carry_nxt = carry_of(sum);
    assign is_last   = (idx_p0 == LAST_IDX);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_p0  <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            idx_p0    <= '0;
            carry_p0  <= '0;
        end else begin
            case (state_p0)
                IDLE: begin
                    if (in_valid) begin
                        state_p0  <= RUN;
                        in_ready  <= 1'b0;
                        out_valid <= 1'b1;
                        idx_p0    <= '0;
                        carry_p0  <= '0;
                    end
                end
                RUN: begin
                    if (out_ready) begin
                        carry_p0 <= carry_nxt;
                        if (is_last) begin
`ifdef REDUN_NORM_CARRY_BEAT_EN
                            state_p0  <= CARRY;
`else
                            state_p0  <= IDLE;
                            in_ready  <= 1'b1;
                            out_valid <= 1'b0;
`endif
                        end else begin
                            idx_p0 <= idx_p0 + 1'b1;
                        end
                    end
                end
`ifdef REDUN_NORM_CARRY_BEAT_EN
                CARRY: begin
                    if (out_ready) begin
                        state_p0  <= IDLE;
                        in_ready  <= 1'b1;
                        out_valid <= 1'b0;
                    end
                end
`endif
                default: begin
                    state_p0  <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    // Outputs decode registered state only, so they hold steady under backpressure
    always_comb begin
        out_word  = '0;
        out_last  = 1'b0;
        out_carry = '0;
        if (state_p0 == RUN) begin
            out_word = sum[WORD_LEN-1:0];
`ifndef REDUN_NORM_CARRY_BEAT_EN
            out_last  = is_last;
            out_carry = is_last ? carry_nxt : '0;
`endif
        end
`ifdef REDUN_NORM_CARRY_BEAT_EN
        if (state_p0 == CARRY) begin
            out_word = {{(WORD_LEN-CARRY_LEN){1'b0}}, carry_p0};
            out_last = 1'b1;
        end
`endif
    end

endmodule

// File: tb/tb_redun_normalizer.sv
// Directed-vector bench for redun_normalizer with NUM_WORDS=4.
module tb_redun_normalizer;
    localparam int NW  = 4;
    localparam int IBL = 17;
    localparam int WL  = 16;
    localparam int CL  = IBL - WL + 1;
`ifdef REDUN_NORM_CARRY_BEAT_EN
    localparam int NB = NW + 1;
`else
    localparam int NB = NW;
`endif

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [IBL-1:0] in_words [NW];
    logic           out_valid;
    logic           out_ready = 1'b1;
    logic [WL-1:0]  out_word;
    logic           out_last;
    logic [CL-1:0]  out_carry;

    logic [WL-1:0]  exp_w [NW];
    int             n_chk = 0;
    int             n_err = 0;
    int             cyc;

    always #5 clk = ~clk;

    redun_normalizer #(
        .NUM_WORDS (NW),
        .IN_BIT_LEN(IBL),
        .WORD_LEN  (WL)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_words (in_words),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_word (out_word),
        .out_last (out_last),
        .out_carry(out_carry)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", tag, act, exp, $time);
        end
    endtask

    task automatic load(input logic [IBL-1:0] a, input logic [IBL-1:0] b,
                        input logic [IBL-1:0] c, input logic [IBL-1:0] d);
        in_words[0] = a; in_words[1] = b; in_words[2] = c; in_words[3] = d;
    endtask

    task automatic expect_words(input logic [WL-1:0] a, input logic [WL-1:0] b,
                                input logic [WL-1:0] c, input logic [WL-1:0] d);
        exp_w[0] = a; exp_w[1] = b; exp_w[2] = c; exp_w[3] = d;
    endtask

    // Called at a sample point; returns at the sample point after acceptance.
    task automatic send();
        int t = 0;
        in_valid = 1'b1;
        while (!in_ready && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        check("accept_wait", 32'(t < 50), 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("first_beat_valid", 32'(out_valid), 1);
        check("busy_in_ready", 32'(in_ready), 0);
    endtask

    // Consumes all beats of one packet; ec is the packet's final carry.
    task automatic recv(input logic [CL-1:0] ec, input int stall_beat, input int stall_n,
                        output int ncyc);
        ncyc = 0;
        for (int i = 0; i < NB; i++) begin
            int t = 0;
            logic [WL-1:0] ew;
            ew = (i < NW) ? exp_w[i] : WL'(ec);
            while (!out_valid && t < 50) begin
                @(posedge clk); #1;
                t++;
            end
            check("beat_wait", 32'(t < 50), 1);
            if (i == stall_beat) begin
                out_ready = 1'b0;
                for (int s = 0; s < stall_n; s++) begin
                    check("stall_valid", 32'(out_valid), 1);
                    check("stall_word", 32'(out_word), 32'(ew));
                    @(posedge clk); #1;
                    ncyc++;
                end
                out_ready = 1'b1;
            end
            check("word", 32'(out_word), 32'(ew));
            check("last", 32'(out_last), 32'(i == NB - 1));
            check("carry", 32'(out_carry), (i == NB - 1 && NB == NW) ? 32'(ec) : 0);
            check("in_ready_busy", 32'(in_ready), 0);
            @(posedge clk); #1;
            ncyc++;
        end
        check("done_valid", 32'(out_valid), 0);
        check("done_in_ready", 32'(in_ready), 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        load(0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_last", 32'(out_last), 0);
        check("rst_out_carry", 32'(out_carry), 0);
        check("rst_out_word", 32'(out_word), 0);
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk); #1;

        // Carry ripples from word 1 into word 2
        load(17'h1FFFF, 17'h1FFFF, 17'h00000, 17'h00000);
        expect_words(16'hFFFF, 16'h0000, 16'h0002, 16'h0000);
        send();
        recv(0, -1, 0, cyc);
        check("t1_cycles", 32'(cyc), 32'(NB));

        // Backpressure on beat 1
        send();
        recv(0, 1, 3, cyc);
        check("bp_cycles", 32'(cyc), 32'(NB + 3));

        // Back-to-back: all-ones packet then the first packet, in_valid held
        load(17'h1FFFF, 17'h1FFFF, 17'h1FFFF, 17'h1FFFF);
        expect_words(16'hFFFF, 16'h0000, 16'h0001, 16'h0001);
        in_valid = 1'b1;
        @(posedge clk); #1;
        check("b2b_a_valid", 32'(out_valid), 1);
        load(17'h1FFFF, 17'h1FFFF, 17'h00000, 17'h00000);
        recv(2, -1, 0, cyc);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("b2b_b_accept", 32'(out_valid), 1);
        check("b2b_b_in_ready", 32'(in_ready), 0);
        expect_words(16'hFFFF, 16'h0000, 16'h0002, 16'h0000);
        recv(0, -1, 0, cyc);

        // Asynchronous reset after beat 1 handshake
        load(17'h1FFFF, 17'h1FFFF, 17'h00000, 17'h00000);
        send();
        check("rm_beat0", 32'(out_word), 32'hFFFF);
        @(posedge clk); #1;
        check("rm_beat1", 32'(out_word), 32'h0000);
        @(posedge clk); #1;
        #2 reset_n = 1'b0;
        #1;
        check("rm_out_valid", 32'(out_valid), 0);
        check("rm_in_ready", 32'(in_ready), 1);
        check("rm_out_last", 32'(out_last), 0);
        check("rm_out_word", 32'(out_word), 0);
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk); #1;
        load(17'd1, 17'd2, 17'd3, 17'd4);
        expect_words(16'h0001, 16'h0002, 16'h0003, 16'h0004);
        send();
        recv(0, -1, 0, cyc);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
